updown_counter16: RTL and testbench

Registered 16-bit up/down counter that steps by ±1 per clock, with synchronous parallel load and registered wrap/saturate indication. It is the decrementing counterpart to the combinational 16-bit incrementer: the increment path reuses that arithmetic, and a matching decrement path is added. It sits in the CPU datapath as a general counter and loop/stack-pointer register. It is the sequential building block for program-counter and stack-pointer style registers.

---
 rtl/updown_counter16.sv | 94 +++++++++
 tb/tb_updown_counter16.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter16.sv
// updown_counter16
//   Registered up/down counter with synchronous parallel load and a registered
//   one-cycle pulse flagging any update that crossed a limit (wrapped or was
//   clamped). Used as a general datapath counter and as the core of
//   program-counter / stack-pointer style registers.
//
// Parameters
//   WIDTH       counter width in bits; arithmetic is modulo 2^WIDTH
//   RESET_VALUE value forced onto `out` while `reset` is high
//   SATURATE    0: wrap around at the limits, 1: clamp at all-zeros / all-ones
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   load   in   load `in` on the next edge (highest priority)
//   in     in   parallel load value
//   inc    in   count up by one
//   dec    in   count down by one (inc and dec together hold)
//   out    out  registered counter value
//   zero   out  combinational, high when out == 0
//   wrap   out  registered, high for the cycle after a limit crossing
module updown_counter16 #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SATURATE    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ZEROS = '0;
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;

  // Same arithmetic as the standalone combinational incrementer.
  function automatic logic [WIDTH-1:0] incr(input logic [WIDTH-1:0] v);
    return v + WIDTH'(1);
  endfunction

  // Decrement as an add of all-ones; the carry-out is simply dropped.
  function automatic logic [WIDTH-1:0] decr(input logic [WIDTH-1:0] v);
    return v + ALL_ONES;
  endfunction

  logic [WIDTH-1:0] next_out;
  logic             next_wrap;

  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    next_out  = out;
    next_wrap = 1'b0;

    if (load) begin
      next_out = in;
    end else if (inc && !dec) begin
      // Limit detection looks at the current value, not at the adder carry.
      if (out == ALL_ONES) begin
        next_wrap = 1'b1;
        next_out  = SATURATE ? out : incr(out);
      end else begin
        next_out  = incr(out);
      end
    end else if (dec && !inc) begin
      if (out == ALL_ZEROS) begin
        next_wrap = 1'b1;
        next_out  = SATURATE ? out : decr(out);
      end else begin
        next_out  = decr(out);
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out  <= RESET_VALUE;
      wrap <= 1'b0;
    end else begin
      out  <= next_out;
      wrap <= next_wrap;
    end
  end

  assign zero = (out == ALL_ZEROS);

endmodule

// File: tb/tb_updown_counter16.sv
// tb_updown_counter16
//   Drives one wrapping and one saturating instance with identical stimulus.
//   The driver pushes the expected post-edge state of both counters into a
//   queue; an independent monitor pops one entry per clock edge and compares.
module tb_updown_counter16;

  localparam logic [15:0] RV = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] din = '0;
  logic        inc = 1'b0;
  logic        dec = 1'b0;

  logic [15:0] out0, out1;
  logic        zero0, zero1, wrap0, wrap1;

  updown_counter16 #(.WIDTH(16), .RESET_VALUE(RV), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .load(load), .in(din), .inc(inc), .dec(dec),
    .out(out0), .zero(zero0), .wrap(wrap0)
  );

  updown_counter16 #(.WIDTH(16), .RESET_VALUE(RV), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .load(load), .in(din), .inc(inc), .dec(dec),
    .out(out1), .zero(zero1), .wrap(wrap1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned val0;
    bit          w0;
    int unsigned val1;
    bit          w1;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int n_checks    = 0;

  // Reference state of each counter, held as plain integers 0..65535.
  int unsigned m0 = 0;
  int unsigned m1 = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Counter behaviour from its rules, in integer arithmetic.
  task automatic model(input int unsigned v, input bit sat, input bit l,
                       input int unsigned d, input bit i, input bit dn,
                       output int unsigned nv, output bit w);
    nv = v;
    w  = 1'b0;
    if (l) begin
      nv = d;
    end else if (i && !dn) begin
      w  = (v == 65535);
      nv = (w && sat) ? v : (v + 1) % 65536;
    end else if (dn && !i) begin
      w  = (v == 0);
      nv = (w && sat) ? v : (v + 65535) % 65536;
    end
  endtask

  // One clock of stimulus; also releases any reset left asserted.
  task automatic step(input bit l, input logic [15:0] v, input bit i, input bit d);
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    load  = l;
    din   = v;
    inc   = i;
    dec   = d;
    model(m0, 1'b0, l, int'(v), i, d, e.val0, e.w0);
    model(m1, 1'b1, l, int'(v), i, d, e.val1, e.w1);
    m0 = e.val0;
    m1 = e.val1;
    exp_q.push_back(e);
    vectors++;
    @(posedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out0"},  out0, RV);
    check({tag, "_zero0"}, {15'd0, zero0}, {15'd0, RV == 16'h0000});
    check({tag, "_wrap0"}, {15'd0, wrap0}, 16'h0000);
    check({tag, "_out1"},  out1, RV);
    check({tag, "_wrap1"}, {15'd0, wrap1}, 16'h0000);
  endtask

  // Assert reset between edges with the given inc level and verify the
  // outputs move without an edge; reset stays high until the next step.
  task automatic async_reset(input bit keep_inc);
    @(negedge clk);
    load = 1'b0;
    dec  = 1'b0;
    inc  = keep_inc;
    #2 reset = 1'b1;
    #1 check_reset_values("async_rst");
    m0 = int'(RV);
    m1 = int'(RV);
    @(posedge clk);
    #1 check_reset_values("rst_hold");
  endtask

  // Monitor: every edge presents a result; compare against the oldest entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_wrapmode", out0, 16'(e.val0));
        check("zero_wrapmode", {15'd0, zero0}, {15'd0, e.val0 == 0});
        check("wrap_wrapmode", {15'd0, wrap0}, {15'd0, e.w0});
        check("out_satmode", out1, 16'(e.val1));
        check("zero_satmode", {15'd0, zero1}, {15'd0, e.val1 == 0});
        check("wrap_satmode", {15'd0, wrap1}, {15'd0, e.w1});
      end
    end
  end

  initial begin
    logic [15:0] rv;
    int          sel;
    int          budget;

    // Power-on reset, checked before any clock edge.
    #1 reset = 1'b1;
    #1 check_reset_values("por");

    // Reset mid-run with a non-zero value.
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    async_reset(1'b0);

    // Up count for 16 edges.
    for (int k = 0; k < 16; k++) step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Crossing both limits, then idle.
    step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Back-to-back decrements from zero.
    step(1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Increment from all-ones.
    step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Priority: load beats inc/dec, inc+dec holds, dec alone steps down.
    step(1'b1, 16'h000F, 1'b0, 1'b0);
    step(1'b1, 16'h0100, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Reset between edges with inc high; release with inc still high.
    async_reset(1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Randomized traffic biased towards the limits.
    for (int k = 0; k < 400; k++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: rv = 16'h0000;
        1: rv = 16'hFFFF;
        2: rv = 16'h0001;
        3: rv = 16'hFFFE;
        default: rv = 16'($urandom);
      endcase
      step(($urandom_range(0, 7) == 0), rv,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Drain the scoreboard with a bounded wait.
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
